// File: rtl/button_conditioner.sv
// Synchronises, debounces and edge-detects three VGA game buttons (left, right, select).
// Define BTN_AUTOREPEAT_EN to add timed auto-repeat strobes on left/right.
module button_conditioner #(
  parameter int DEBOUNCE_TICKS = 3,
  parameter int REPEAT_DELAY   = 20,
  parameter int REPEAT_RATE    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [2:0] btn_in,
  output logic [2:0] btn_level,
  output logic [2:0] btn_press
);

  if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 15 ||
      REPEAT_DELAY < 1 || REPEAT_DELAY > 63 ||
      REPEAT_RATE < 1 || REPEAT_RATE > 63) begin : g_bad_param
    $error("button_conditioner: parameter out of range");
  end

  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_TICKS - 1);

  logic [2:0] meta;
  logic [2:0] sync;
  logic [3:0] cnt [3];
  logic [2:0] level_nxt;
  logic [2:0] rise;
  logic [2:0] rep;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= btn_in;
      sync <= meta;
    end
  end

  always_comb begin
    level_nxt = btn_level;
    for (int i = 0; i < 3; i++) begin
      if (tick && sync[i] != btn_level[i] && cnt[i] == DB_LAST)
        level_nxt[i] = sync[i];
    end
    rise = level_nxt & ~btn_level;
  end

  // Any cycle where sync agrees with the level wipes partial progress, so glitches never accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
      btn_level <= '0;
      btn_press <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync[i] == btn_level[i])
          cnt[i] <= '0;
        else if (tick)
          cnt[i] <= (cnt[i] == DB_LAST) ? 4'd0 : cnt[i] + 4'd1;
      end
      btn_level <= level_nxt;
      btn_press <= rise | rep;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [6:0] DELAY7 = 7'(REPEAT_DELAY);
  localparam logic [6:0] RATE7  = 7'(REPEAT_RATE);

  logic [5:0] rcnt [2];
  logic [1:0] armed;
  logic [6:0] rnxt [2];
  logic [1:0] hit;

  // Repeats only fire while the level stays high, and never back-to-back with another strobe.
  always_comb begin
    rep = '0;
    for (int i = 0; i < 2; i++) begin
      rnxt[i] = {1'b0, rcnt[i]} + 7'd1;
      hit[i]  = tick && (rnxt[i] >= (armed[i] ? RATE7 : DELAY7));
      rep[i]  = btn_level[i] && level_nxt[i] && hit[i] && !btn_press[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) rcnt[i] <= '0;
      armed <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!btn_level[i]) begin
          rcnt[i]  <= '0;
          armed[i] <= 1'b0;
        end else if (rep[i]) begin
          rcnt[i]  <= '0;
          armed[i] <= 1'b1;
        end else if (tick && !hit[i]) begin
          rcnt[i] <= rnxt[i][5:0];
        end
      end
    end
  end
`else
  assign rep = 3'b000;
`endif

endmodule
